// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the requesters/consumer and mux_rr_arbiter.
// The master modport is the environment side; the slave modport is the arbiter.
interface mux_rr_arbiter_if #(
    parameter int BIT_WIDTH = 4,
    parameter int DEPTH     = 4,
    parameter int SEL_WIDTH = 2
);
    logic [DEPTH-1:0]           req_valid;
    logic [DEPTH-1:0]           req_ready;
    logic [BIT_WIDTH*DEPTH-1:0] req_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [BIT_WIDTH-1:0]       out_data;
    logic [SEL_WIDTH-1:0]       select;
    logic [DEPTH-1:0]           grant;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, select, grant
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, select, grant
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one mux among DEPTH requesters into a one-entry output register.
// Define MUX_ARB_BURST_EN to let a winner repeat up to MAX_BURST consecutive grants.
module mux_rr_arbiter #(
    parameter int BIT_WIDTH = 4,
    parameter int DEPTH     = 4,
    parameter int SEL_WIDTH = 2,
    parameter int MAX_BURST = 4
) (
    input logic             clk,
    input logic             rst,
    mux_rr_arbiter_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t                          state;
    logic [SEL_WIDTH-1:0]            ptr;
    logic [SEL_WIDTH-1:0]            win;
    logic [SEL_WIDTH-1:0]            win_inc;
    logic                            any_valid;
    logic                            slot_free;
    logic                            accept;
    logic [DEPTH-1:0][BIT_WIDTH-1:0] words;
    logic [BIT_WIDTH-1:0]            mux_word;

`ifdef MUX_ARB_BURST_EN
    localparam int BCW = $clog2(MAX_BURST + 1);
    logic [BCW-1:0] burst_cnt;
    logic           burst_act;
    logic           repeat_win;

    // The last winner keeps the slot while it stays valid and has burst budget left.
    assign repeat_win = burst_act && bus.req_valid[bus.select] &&
                        (burst_cnt < BCW'(MAX_BURST - 1));
`endif

    assign words     = bus.req_data;
    assign slot_free = (state == EMPTY) | bus.out_ready;
    assign accept    = any_valid & slot_free & ~rst;
    assign win_inc   = (win == SEL_WIDTH'(DEPTH - 1)) ? '0 : win + 1'b1;

    assign bus.req_ready = accept ? (DEPTH'(1) << win) : '0;
    assign bus.out_valid = (state == FULL);

    // Lowest valid index at or above ptr wins; otherwise the lowest valid index (wrap).
    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                win       = SEL_WIDTH'(i);
                any_valid = 1'b1;
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (SEL_WIDTH'(i) >= ptr))
                win = SEL_WIDTH'(i);
        end
`ifdef MUX_ARB_BURST_EN
        if (repeat_win)
            win = bus.select;
`endif
    end

    always_comb begin
        mux_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (win == SEL_WIDTH'(i))
                mux_word = words[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            bus.out_data <= '0;
            bus.select   <= '0;
            bus.grant    <= '0;
            ptr          <= '0;
`ifdef MUX_ARB_BURST_EN
            burst_cnt    <= '0;
            burst_act    <= 1'b0;
`endif
        end else if (accept) begin
            state        <= FULL;
            bus.out_data <= mux_word;
            bus.select   <= win;
            bus.grant    <= DEPTH'(1) << win;
`ifdef MUX_ARB_BURST_EN
            burst_act    <= 1'b1;
            if (repeat_win) begin
                burst_cnt <= burst_cnt + 1'b1;
            end else begin
                burst_cnt <= '0;
                ptr       <= win_inc;
            end
`else
            ptr          <= win_inc;
`endif
        end else begin
            if (state == FULL && bus.out_ready) begin
                state     <= EMPTY;
                bus.grant <= '0;
            end
`ifdef MUX_ARB_BURST_EN
            if (burst_act && !bus.req_valid[bus.select]) begin
                burst_act <= 1'b0;
                burst_cnt <= '0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: expected {out_data, select} pairs are queued with the
// stimulus and checked whenever the consumer takes a word; other checks are inline.
module tb_mux_rr_arbiter;
    localparam int BW = 4;
    localparam int D  = 4;
    localparam int SW = 2;
    localparam int MB = 2;
`ifdef MUX_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.BIT_WIDTH(BW), .DEPTH(D), .SEL_WIDTH(SW)) bus ();

    mux_rr_arbiter #(.BIT_WIDTH(BW), .DEPTH(D), .SEL_WIDTH(SW), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    logic [BW+SW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [BW-1:0] data, input logic [SW-1:0] sel);
        exp_q.push_back({data, sel});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a word is consumed on every edge where out_valid & out_ready.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0)
                chk("sb_unexpected_word", 32'(bus.out_valid), 32'd0);
            else
                chk("sb_word", 32'({bus.out_data, bus.select}), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        // Reset with all requesters valid
        rst           = 1'b1;
        bus.req_valid = '1;
        bus.req_data  = 16'hDCBA;
        bus.out_ready = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_select",    32'(bus.select),    32'd0);
        chk("rst_grant",     32'(bus.grant),     32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);

        // Fairness: A,B,C,D,A one per cycle
        step();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        if (BURST) begin
            push(4'hA, 2'd0); push(4'hA, 2'd0); push(4'hB, 2'd1); push(4'hB, 2'd1); push(4'hC, 2'd2);
        end else begin
            push(4'hA, 2'd0); push(4'hB, 2'd1); push(4'hC, 2'd2); push(4'hD, 2'd3); push(4'hA, 2'd0);
        end
        @(negedge clk);
        chk("fair_first_ready", 32'(bus.req_ready), 32'h1);
        chk("fair_latency",     32'(bus.out_valid), 32'd0);
        repeat (5) step();
        bus.req_valid = '0;
        step();
        @(negedge clk);
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_grant",     32'(bus.grant),     32'd0);
        chk("drain_data_kept", 32'(bus.out_data),  BURST ? 32'hC : 32'hA);
        chk("drain_sel_kept",  32'(bus.select),    BURST ? 32'd2 : 32'd0);

        // Backpressure on requester 2
        step();
        bus.req_valid = 4'b0100;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_ready", 32'(bus.req_ready), 32'h4);
        step();
        bus.req_data = 16'hD5BA;
        @(negedge clk);
        chk("bp_ready_blocked", 32'(bus.req_ready), 32'h0);
        chk("bp_valid",         32'(bus.out_valid), 32'd1);
        chk("bp_data",          32'(bus.out_data),  32'hC);
        chk("bp_grant",         32'(bus.grant),     32'h4);
        step();
        @(negedge clk);
        chk("bp_data_hold",   32'(bus.out_data),  32'hC);
        chk("bp_grant_hold",  32'(bus.grant),     32'h4);
        chk("bp_ready_hold",  32'(bus.req_ready), 32'h0);
        step();
        push(4'hC, 2'd2);
        push(4'h5, 2'd2);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(bus.req_ready), 32'h4);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        step();

        // Wrap: req 3, then 1001 -> req 0
        bus.req_valid = 4'b1000;
        push(4'hD, 2'd3);
        @(negedge clk);
        chk("wrap_ready3", 32'(bus.req_ready), 32'h8);
        step();
        bus.req_valid = 4'b1001;
        if (BURST) push(4'hD, 2'd3);
        else       push(4'hA, 2'd0);
        @(negedge clk);
        chk("wrap_ready0", 32'(bus.req_ready), BURST ? 32'h8 : 32'h1);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk("wrap_select", 32'(bus.select), BURST ? 32'd3 : 32'd0);
        chk("wrap_grant",  32'(bus.grant),  BURST ? 32'h8 : 32'h1);
        step();

        // Requesters 1 and 2 always valid
        bus.req_valid = 4'b0110;
        if (BURST) begin
            push(4'hB, 2'd1); push(4'hB, 2'd1); push(4'h5, 2'd2); push(4'h5, 2'd2);
        end else begin
            push(4'hB, 2'd1); push(4'h5, 2'd2); push(4'hB, 2'd1); push(4'h5, 2'd2);
        end
        repeat (4) step();
        bus.req_valid = '0;
        step();

        // Reset while FULL and stalled
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0100;
        step();
        @(negedge clk);
        chk("mid_full", 32'(bus.out_valid), 32'd1);
        step();
        rst           = 1'b1;
        bus.req_valid = '1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        step();
        rst           = 1'b0;
        bus.req_valid = 4'b1010;
        bus.out_ready = 1'b1;
        push(4'hB, 2'd1);
        @(negedge clk);
        chk("mid_cleared",   32'(bus.out_valid), 32'd0);
        chk("mid_grant",     32'(bus.grant),     32'h0);
        chk("mid_ptr_reset", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("end_empty",  32'(bus.out_valid),  32'd0);
        chk("sb_drained", 32'(exp_q.size()),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
